// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Passive side of a 4x3 matrix keypad. A pressed key (r,c) shorts row r to
//   column c. The scanner drives the column strobes and reads the rows back.
//   Each accepted command runs one complete press:
//   press bounce -> solid hold -> release bounce -> open gap.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   col[2:0]   column strobes from the scanner (active-high)
//   key_valid  command valid
//   key_code   key to press, row*3+col, 0..11
//   key_ready  high in IDLE; a command is taken on key_valid && key_ready
//   row[3:0]   row sense lines (active-high), combinational from col
//   busy       high whenever a press sequence is in progress
//   done       one-cycle pulse in the first IDLE cycle after a sequence
//   err        one-cycle pulse after an out-of-range code offered in IDLE
module keypad_emulator #(
   parameter int BOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 50,
   parameter int GAP_CYCLES    = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] col,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   output logic [3:0] row,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int MAXC0 = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
   localparam int MAXC  = (MAXC0 > GAP_CYCLES) ? MAXC0 : GAP_CYCLES;
   // Counter holds N-1 down to 0, so MAXC-1 is the largest value stored.
   localparam int CW    = (MAXC < 2) ? 1 : $clog2(MAXC);
   localparam bit HAS_B = (BOUNCE_CYCLES > 0);
   localparam logic [CW-1:0] B_LD = CW'(HAS_B ? BOUNCE_CYCLES - 1 : 0);
   localparam logic [CW-1:0] H_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRESS, S_HOLD, S_REL, S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          contact_q, contact_d;
   logic [1:0]    r_q, r_d, c_q, c_d;
   logic          done_q, done_d, err_q, err_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         contact_q <= 1'b0;
         r_q       <= '0;
         c_q       <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         contact_q <= contact_d;
         r_q       <= r_d;
         c_q       <= c_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Each timed state is left when the counter reaches 0. The counter is
   // loaded with N-1 on entry, so the state lasts exactly N cycles.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      contact_d = contact_q;
      r_d       = r_q;
      c_d       = c_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            contact_d = 1'b0;
            if (key_valid) begin
               if (key_code <= 4'd11) begin
                  r_d       = 2'(key_code / 4'd3);
                  c_d       = 2'(key_code % 4'd3);
                  contact_d = 1'b1;  // press bounce and hold both start closed
                  if (HAS_B) begin
                     state_d = S_PRESS;
                     cnt_d   = B_LD;
                  end else begin
                     state_d = S_HOLD;
                     cnt_d   = H_LD;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_PRESS: begin
            if (cnt_q == '0) begin
               state_d   = S_HOLD;
               cnt_d     = H_LD;
               contact_d = 1'b1;
            end else begin
               cnt_d     = cnt_q - CW'(1);
               contact_d = ~contact_q;
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               contact_d = 1'b0;  // release bounce starts open
               if (HAS_B) begin
                  state_d = S_REL;
                  cnt_d   = B_LD;
               end else begin
                  state_d = S_GAP;
                  cnt_d   = G_LD;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_REL: begin
            if (cnt_q == '0) begin
               state_d   = S_GAP;
               cnt_d     = G_LD;
               contact_d = 1'b0;
            end else begin
               cnt_d     = cnt_q - CW'(1);
               contact_d = ~contact_q;
            end
         end
         S_GAP: begin
            contact_d = 1'b0;
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d   = S_IDLE;
            contact_d = 1'b0;
         end
      endcase
   end

   // Passive switch: no register between col and row.
   always_comb begin
      row = 4'b0000;
      if (contact_q && col[c_q]) row[r_q] = 1'b1;
   end

   assign key_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] col = 3'b000;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       rdy [2];
   logic       bsy [2];
   logic       dn  [2];
   logic       er  [2];
   logic [3:0] rw  [2];

   always #5 clk = ~clk;

   keypad_emulator dut0 (
      .clk(clk), .reset(reset), .col(col), .key_valid(key_valid), .key_code(key_code),
      .key_ready(rdy[0]), .row(rw[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0])
   );

   keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(3), .GAP_CYCLES(10)) dut1 (
      .clk(clk), .reset(reset), .col(col), .key_valid(key_valid), .key_code(key_code),
      .key_ready(rdy[1]), .row(rw[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1])
   );

   int nchk = 0;
   int nfail = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // t = cycle number within the press (1 = first cycle after the accept edge).
   int BP [2] = '{4, 0};
   int HP [2] = '{50, 3};
   int GP [2] = '{10, 10};
   bit act [2];
   int t   [2];
   int mr  [2];
   int mc  [2];
   bit edn [2];
   bit eer [2];

   function automatic bit contact_at(input int i, input int tt);
      int b = BP[i];
      int h = HP[i];
      if (tt <= b)         return (tt % 2) == 1;
      if (tt <= b + h)     return 1'b1;
      if (tt <= 2 * b + h) return ((tt - b - h) % 2) == 0;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         edn[i] = 0;
         eer[i] = 0;
         if (reset) begin
            act[i] = 0;
            t[i]   = 0;
         end else if (act[i]) begin
            t[i]++;
            if (t[i] == 2 * BP[i] + HP[i] + GP[i] + 1) begin
               act[i] = 0;
               edn[i] = 1;
            end
         end else if (key_valid) begin
            if (key_code < 12) begin
               act[i] = 1;
               t[i]   = 1;
               mr[i]  = int'(key_code) / 3;
               mc[i]  = int'(key_code) % 3;
            end else begin
               eer[i] = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            logic [3:0] e;
            e = 4'b0000;
            if (act[i] && contact_at(i, t[i]) && col[mc[i]]) e[mr[i]] = 1'b1;
            chk($sformatf("row%0d", i),   8'(rw[i]),  8'(e));
            chk($sformatf("busy%0d", i),  8'(bsy[i]), 8'(act[i]));
            chk($sformatf("ready%0d", i), 8'(rdy[i]), 8'(!act[i]));
            chk($sformatf("done%0d", i),  8'(dn[i]),  8'(edn[i]));
            chk($sformatf("err%0d", i),   8'(er[i]),  8'(eer[i]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle();
      int k = 0;
      while (!(rdy[0] && rdy[1]) && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 300) begin
         nchk++;
         nfail++;
         $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
      end
   endtask

   // Offers one command in the current cycle; returns just after the accept edge.
   task automatic send(input logic [3:0] code, input logic [2:0] cl);
      key_code  = code;
      col       = cl;
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_row",   8'(rw[0]),  8'h0);
      chk("rst_ready", 8'(rdy[0]), 8'h1);
      chk("rst_busy",  8'(bsy[0]), 8'h0);
      chk("rst_done",  8'(dn[0]),  8'h0);
      chk("rst_err",   8'(er[0]),  8'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Key 0 on both instances, col held at 001.
      send(4'd0, 3'b001);
      for (int n = 1; n <= 69; n++) begin
         @(negedge clk);
         if (n == 1 || n == 3 || n == 5 || n == 54) chk($sformatf("t1_row_c%0d", n), 8'(rw[0]), 8'h1);
         if (n == 2 || n == 4 || n == 59 || n == 68) chk($sformatf("t1_row_c%0d", n), 8'(rw[0]), 8'h0);
         if (n == 68) chk("t1_done_c68", 8'(dn[0]), 8'h0);
         if (n == 69) begin
            chk("t1_done_c69",  8'(dn[0]),  8'h1);
            chk("t1_ready_c69", 8'(rdy[0]), 8'h1);
         end
         if (n <= 3) chk($sformatf("b0_row_c%0d", n), 8'(rw[1]), 8'h1);
         if (n == 4) chk("b0_row_c4", 8'(rw[1]), 8'h0);
         if (n == 13) chk("b0_done_c13", 8'(dn[1]), 8'h0);
         if (n == 14) chk("b0_done_c14", 8'(dn[1]), 8'h1);
      end

      // Key 4 with a rotating column strobe.
      wait_idle();
      send(4'd4, 3'b001);
      for (int n = 1; n <= 70; n++) begin
         @(negedge clk);
         if (n >= 5 && n <= 54) chk($sformatf("t2_row_c%0d", n), 8'(rw[0]),
                                    (col == 3'b010) ? 8'h2 : 8'h0);
         @(posedge clk); #1;
         col = {col[1:0], col[2]};
      end

      // Key 11 on col 100, then an out-of-range code.
      wait_idle();
      send(4'd11, 3'b100);
      repeat (20) @(negedge clk);
      chk("t3_row_hold", 8'(rw[0]), 8'h8);
      wait_idle();
      key_code  = 4'd13;
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      @(negedge clk);
      chk("t3_err_pulse", 8'(er[0]),  8'h1);
      chk("t3_err_ready", 8'(rdy[0]), 8'h1);
      chk("t3_err_row",   8'(rw[0]),  8'h0);
      chk("t3_err_done",  8'(dn[0]),  8'h0);
      @(negedge clk);
      chk("t3_err_gone",  8'(er[0]),  8'h0);

      // Command offered during HOLD is ignored until the next IDLE.
      wait_idle();
      send(4'd0, 3'b001);
      repeat (19) @(posedge clk);
      #1;
      key_code  = 4'd2;
      key_valid = 1'b1;
      for (int n = 20; n <= 69; n++) begin
         @(negedge clk);
         chk($sformatf("t4_done_c%0d", n), 8'(dn[0]), (n == 69) ? 8'h1 : 8'h0);
      end
      @(posedge clk); #1;
      key_valid = 1'b0;
      @(negedge clk);
      chk("t4_accept_busy", 8'(bsy[0]), 8'h1);

      // Reset in the middle of HOLD.
      wait_idle();
      send(4'd0, 3'b001);
      repeat (20) @(negedge clk);
      chk("t5_row_before", 8'(rw[0]), 8'h1);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_row",   8'(rw[0]),  8'h0);
      chk("t5_async_busy",  8'(bsy[0]), 8'h0);
      chk("t5_async_ready", 8'(rdy[0]), 8'h1);
      chk("t5_async_done",  8'(dn[0]),  8'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      wait_idle();
      send(4'd7, 3'b010);
      repeat (20) @(negedge clk);
      chk("t5_row_key7", 8'(rw[0]), 8'h4);
      wait_idle();

      // Randomized traffic, checked every cycle by the model.
      repeat (4000) begin
         @(posedge clk); #1;
         col       = 3'($urandom_range(0, 7));
         key_valid = ($urandom_range(0, 3) == 0);
         key_code  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                                 : 4'($urandom_range(0, 11));
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1;
            #2 reset = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable model of the physical 4x3 matrix keypad, i.e. the passive side of the column-scan / row-sense interface.
- Watches the column strobes driven by the scanner and returns the row pattern of a "pressed" key, including contact bounce on press and release.
- A valid/ready command port lets a bench or on-board self-test sequence keypresses.
- Sits between the stimulus source and the keypad scanner inside the candy vending system.

Parameters:
- BOUNCE_CYCLES, 4: cycles of contact chatter at press and again at release; 0 means no bounce phase.
- HOLD_CYCLES, 50: cycles of solid contact between the two bounce phases; must be at least 1.
- GAP_CYCLES, 10: cycles of guaranteed open contact after release, before the next command is accepted; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- col  input  3  column strobes from the scanner, active-high; bit c selects column c.
- key_valid  input  1  command valid.
- key_code  input  4  key to press; code = row*3 + col, valid range 0..11.
- key_ready  output  1  high in IDLE; a command is accepted on a rising edge with key_valid && key_ready.
- row  output  4  row sense lines to the scanner, active-high.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a press sequence completes.
- err  output  1  one-cycle pulse when an out-of-range code (12..15) is offered in IDLE.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; contact, counter, and latched row/column are cleared.
  - row=0 immediately, with no clock needed.
  - key_ready=1, busy=0, done=0, err=0.
- FSM states: IDLE -> PRESS_BOUNCE -> HOLD -> REL_BOUNCE -> GAP -> IDLE.
- IDLE:
  - On key_valid with code <= 11: latch r=code/3 and c=code%3. Go to PRESS_BOUNCE, or to HOLD if BOUNCE_CYCLES=0.
  - On key_valid with code >= 12: err=1 for the next cycle only. Stay in IDLE; no contact.
- PRESS_BOUNCE:
  - Lasts BOUNCE_CYCLES cycles.
  - Contact toggles every cycle, starting at 1 (pattern 1,0,1,0,...).
- HOLD: lasts HOLD_CYCLES cycles with contact=1.
- REL_BOUNCE:
  - Lasts BOUNCE_CYCLES cycles.
  - Contact toggles every cycle, starting at 0 (pattern 0,1,0,1,...).
  - Skipped when BOUNCE_CYCLES=0.
- GAP:
  - Lasts GAP_CYCLES cycles with contact=0.
  - Then return to IDLE; done=1 and key_ready=1 in that same first IDLE cycle.
- Timing (accept edge = cycle 0, defaults):
  - contact active from cycle 1.
  - Bounce in cycles 1..4, hold in 5..54, release bounce in 55..58, gap in 59..68.
  - done and key_ready high in cycle 69.
  - In general, done follows accept by 2*BOUNCE_CYCLES + HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- Row output:
  - Combinational from col: row[i] = contact && (i==r) && col[c]; all other bits 0.
  - Zero latency to col changes, like a passive switch.
- Column strobes:
  - Strobes on columns other than c have no effect.
  - Multiple col bits high: only col[c] matters.
  - col=0 gives row=0.
- Commands while busy: key_valid is ignored (key_ready=0). No queuing, no err.
- done and err are registered and never high in the same cycle.
- Counter: a single down-counter sized for max(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES). It reloads on each state entry and does not wrap.
- Reset mid-sequence: aborts immediately to the reset state; no done pulse. The next command is accepted normally after reset is released.

Test Plan:
- Reset, then hold col=001 constant and send key_code=0: row=0001 in cycles 1,3 and 5..54; row=0000 in cycles 2,4 and 59..68; done=1 in cycle 69 exactly.
- Send key_code=4 and rotate col 001->010->100 each cycle during HOLD: row=0010 only while col=010, otherwise 0000.
- Send key_code=11, col=100, and check row=1000 in HOLD. Then key_code=13 in IDLE: err pulses for one cycle, key_ready stays 1, row stays 0, no done.
- Drive key_valid=1 with code 2 during HOLD of a prior press: it is ignored. Exactly one done occurs, and the new command is accepted in cycle 69.
- Assert reset in cycle 20 (HOLD, row=0001): row=0000 asynchronously, busy=0, key_ready=1, no done. After release, key_code=7 runs a full sequence with row=0100 when col=010.
- With BOUNCE_CYCLES=0 and HOLD_CYCLES=3, send key_code=0 with col=001: row=0001 in cycles 1..3, 0 afterward, done in cycle 14.
